// File: rtl/csr_counter_unit.sv
// Machine-mode cycle/instret counters with mcountinhibit and CSR read/write decode.
// Explicit CSR writes take precedence over the increment of the counter written.
module csr_counter_unit #(
  parameter logic [63:0] CYCLE_INIT   = 64'd0,
  parameter logic [63:0] INSTRET_INIT = 64'd0,
  parameter logic        INHIBIT_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire_valid,
  input  logic        stall,
  input  logic        csr_we,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic [63:0] cycle,
  output logic [63:0] instr_cnt
);

  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  logic        r_inh_cy;
  logic        r_inh_ir;

  logic w_we_cyc_lo;
  logic w_we_cyc_hi;
  logic w_we_ir_lo;
  logic w_we_ir_hi;
  logic w_we_inh;
  logic w_retire;

  // Only the 0xBxx machine addresses are writable; 0xCxx user aliases never match here.
  assign w_we_cyc_lo = csr_we && (csr_waddr == 12'hB00);
  assign w_we_cyc_hi = csr_we && (csr_waddr == 12'hB80);
  assign w_we_ir_lo  = csr_we && (csr_waddr == 12'hB02);
  assign w_we_ir_hi  = csr_we && (csr_waddr == 12'hB82);
  assign w_we_inh    = csr_we && (csr_waddr == 12'h320);
  assign w_retire    = retire_valid && !stall && !r_inh_ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= CYCLE_INIT;
    end else if (w_we_cyc_lo) begin
      r_cycle[31:0] <= csr_wdata;
    end else if (w_we_cyc_hi) begin
      r_cycle[63:32] <= csr_wdata;
    end else if (!r_inh_cy) begin
      r_cycle <= r_cycle + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= INSTRET_INIT;
    end else if (w_we_ir_lo) begin
      r_instret[31:0] <= csr_wdata;
    end else if (w_we_ir_hi) begin
      r_instret[63:32] <= csr_wdata;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  // The inhibit bits update at the same edge the counters sample them, so the write edge sees old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inh_cy <= INHIBIT_INIT;
      r_inh_ir <= INHIBIT_INIT;
    end else if (w_we_inh) begin
      r_inh_cy <= csr_wdata[0];
      r_inh_ir <= csr_wdata[2];
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    csr_hit   = 1'b0;
    case (csr_raddr)
      12'hB00, 12'hC00: begin csr_rdata = r_cycle[31:0];    csr_hit = 1'b1; end
      12'hB80, 12'hC80: begin csr_rdata = r_cycle[63:32];   csr_hit = 1'b1; end
      12'hB02, 12'hC02: begin csr_rdata = r_instret[31:0];  csr_hit = 1'b1; end
      12'hB82, 12'hC82: begin csr_rdata = r_instret[63:32]; csr_hit = 1'b1; end
      12'h320: begin
        csr_rdata = {29'd0, r_inh_ir, 1'b0, r_inh_cy};
        csr_hit   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cycle     = r_cycle;
  assign instr_cnt = r_instret;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Scoreboard bench for csr_counter_unit: expected values are queued as stimulus is driven
// and popped when the DUT state is sampled one time unit after the clock edge.
module tb_csr_counter_unit;

  logic        clk;
  logic        rst_n;
  logic        retire_valid;
  logic        stall;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic [63:0] cycle;
  logic [63:0] instr_cnt;

  typedef struct {
    string        name;
    logic [127:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t it;
  int  checks   = 0;
  int  failures = 0;

  csr_counter_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire_valid (retire_valid),
    .stall        (stall),
    .csr_we       (csr_we),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .csr_hit      (csr_hit),
    .cycle        (cycle),
    .instr_cnt    (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [127:0] e);
    sb.push_back('{n, e});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
    csr_waddr = 12'h000;
    csr_wdata = 32'd0;
  endtask

  task automatic test_reset();
    push("reset_counters", {64'd0, 64'd0});
    push("reset_read_c00", {95'd0, 1'b1, 32'd0});
    push("idle10_counters", {64'd10, 64'd0});
    push("idle10_read_c00", {95'd0, 1'b1, 32'd10});
    push("unmapped_read", {95'd0, 1'b0, 32'd0});
    rst_n = 1'b0;
    csr_raddr = 12'hC00;
    #3;
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
    csr_raddr = 12'h123;
    #1;
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
  endtask

  task automatic test_retire_stall();
    logic [4:0] stall_pat;
    stall_pat = 5'b01010;
    push("retire_stall_counters", {64'd15, 64'd3});
    push("retire_read_c82", {95'd0, 1'b1, 32'd0});
    push("retire_read_b02", {95'd0, 1'b1, 32'd3});
    for (int i = 0; i < 5; i++) begin
      retire_valid = 1'b1;
      stall        = stall_pat[i];
      tick();
    end
    retire_valid = 1'b0;
    stall        = 1'b0;
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    csr_raddr = 12'hC82;
    #1;
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
    csr_raddr = 12'hB02;
    #1;
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
  endtask

  task automatic test_carry();
    push("carry_write_edge", {64'h0000_0000_FFFF_FFFE, 64'd3});
    push("carry_after3", {64'h0000_0001_0000_0001, 64'd3});
    push("carry_read_c80", {95'd0, 1'b1, 32'd1});
    wr(12'hB00, 32'hFFFF_FFFE);
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    repeat (3) tick();
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    csr_raddr = 12'hC80;
    #1;
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
  endtask

  task automatic test_wrap();
    push("wrap_hi_write_holds_lo", {64'hFFFF_FFFF_0000_0001, 64'd3});
    push("wrap_all_ones", {64'hFFFF_FFFF_FFFF_FFFF, 64'd3});
    push("wrap_to_zero", {64'd0, 64'd3});
    wr(12'hB80, 32'hFFFF_FFFF);
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    wr(12'hB00, 32'hFFFF_FFFF);
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    tick();
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
  endtask

  task automatic test_inhibit();
    push("inh_write_edge_old_value", {64'd1, 64'd4});
    push("inh_read_320", {95'd0, 1'b1, 32'h5});
    push("inh_frozen", {64'd1, 64'd4});
    push("inh_clear_edge_still_frozen", {64'd1, 64'd4});
    push("inh_resumed", {64'd2, 64'd5});
    retire_valid = 1'b1;
    wr(12'h320, 32'h5);
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    csr_raddr = 12'h320;
    #1;
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
    repeat (3) tick();
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    wr(12'h320, 32'h0);
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    tick();
    retire_valid = 1'b0;
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
  endtask

  task automatic test_back_to_back();
    push("alias_write_ignored", {64'd3, 64'd5});
    push("instret_write_beats_retire", {64'd4, 64'h55});
    push("cycle_write_keeps_retire", {64'd0, 64'h56});
    push("free_edge_after_writes", {64'd1, 64'h56});
    wr(12'hC02, 32'h55);
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    retire_valid = 1'b1;
    wr(12'hB02, 32'h55);
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    wr(12'hB00, 32'h0);
    retire_valid = 1'b0;
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    tick();
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
  endtask

  task automatic test_async_reset();
    push("pre_reset_counters", {64'd4, 64'h59});
    push("async_reset_counters", {64'd0, 64'd0});
    push("async_reset_read_c00", {95'd0, 1'b1, 32'd0});
    retire_valid = 1'b1;
    repeat (3) tick();
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    csr_raddr = 12'hC00;
    #2;
    rst_n = 1'b0;
    #1;
    it = sb.pop_front(); checks++;
    if ({cycle, instr_cnt} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {cycle, instr_cnt}, it.exp);
    end
    it = sb.pop_front(); checks++;
    if ({95'd0, csr_hit, csr_rdata} !== it.exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", it.name, {csr_hit, csr_rdata}, it.exp[32:0]);
    end
    retire_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    retire_valid = 1'b0;
    stall        = 1'b0;
    csr_we       = 1'b0;
    csr_waddr    = 12'h000;
    csr_wdata    = 32'd0;
    csr_raddr    = 12'h000;
    test_reset();
    test_retire_stall();
    test_carry();
    test_wrap();
    test_inhibit();
    test_back_to_back();
    test_async_reset();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_counter_unit.md
Name: csr_counter_unit

Overview:
- Machine-mode performance counter unit for the RV32 core. Holds the 64-bit cycle and instructions-retired counters.
- Drives the cycle[63:0] and instr_cnt[63:0] buses that the EX-stage ALU selects for RDCYCLE/RDCYCLEH/RDINSTRET/RDINSTRETH.
- Accepts CSR writes from the pipeline's CSR path (mcycle/mcycleh/minstret/minstreth/mcountinhibit) and counts retirements reported by WB.

Parameters:
CYCLE_INIT, 64'd0, cycle counter value loaded at reset
INSTRET_INIT, 64'd0, instret counter value loaded at reset
INHIBIT_INIT, 1'b0, reset value of both mcountinhibit bits (CY = bit0, IR = bit2)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
retire_valid  input  1  one instruction retires in WB this cycle
stall  input  1  pipeline stalled; a retire_valid asserted while stall=1 is not counted
csr_we  input  1  CSR write strobe (one cycle per write)
csr_waddr  input  12  CSR write address
csr_wdata  input  32  CSR write data
csr_raddr  input  12  CSR read address
csr_rdata  output  32  combinational read data for csr_raddr
csr_hit  output  1  csr_raddr maps to an implemented counter CSR
cycle  output  64  current cycle counter (registered)
instr_cnt  output  64  current instret counter (registered)

Behaviour:
- Reset: asynchronous on rst_n=0. cycle=CYCLE_INIT, instr_cnt=INSTRET_INIT, inhibit_cy=inhibit_ir=INHIBIT_INIT. csr_rdata and csr_hit follow these reset values combinationally. Reset mid-count discards the count immediately, with no waiting for a clock edge.
- Address map:
  - 0xB00/0xC00: cycle[31:0]
  - 0xB80/0xC80: cycle[63:32]
  - 0xB02/0xC02: instr_cnt[31:0]
  - 0xB82/0xC82: instr_cnt[63:32]
  - 0x320: mcountinhibit = {29'b0, inhibit_ir, 1'b0, inhibit_cy}
  - 0xCxx addresses are read-only aliases; writes to them are ignored.
  - Any other address: csr_rdata=0, csr_hit=0, writes ignored.
- Cycle counter:
  - Each edge, if inhibit_cy=0 and there is no write to cycle: cycle <= cycle+1.
  - Full 64-bit add. A carry out of bit 31 propagates into the high half in the same cycle.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0, with no flag.
- Instret counter: increments by 1 when retire_valid=1 and stall=0 and inhibit_ir=0 and there is no write to instret this cycle. Same 64-bit wrap rule as cycle.
- Write priority: an explicit CSR write beats the increment for that whole counter in that cycle.
  - Writing the low half loads csr_wdata into [31:0] and holds [63:32].
  - Writing the high half loads [63:32] and holds [31:0].
  - In both cases the counter does not also increment that edge.
- Latency:
  - Writes are visible on cycle/instr_cnt/csr_rdata the cycle after csr_we.
  - A retirement counted at edge N is visible after edge N.
  - mcountinhibit writes take effect for the next edge. The edge that performs the write still uses the old inhibit value.
- Read is purely combinational from registered state. There is no read-modify-write hazard inside this block; the pipeline forwards.
- Simultaneous cases:
  - A write to one counter does not affect increments of the other.
  - A write to 0x320 in the same cycle as retire_valid uses the old inhibit_ir for that retirement.
- No handshake back-pressure. The block is always ready; csr_we is single-cycle and must not be held.

Test Plan:
- Reset, then release with no stimulus for 10 cycles -> cycle=10, instr_cnt=0, csr_rdata@0xC00=10, csr_hit=1; csr_raddr=0x123 -> csr_rdata=0, csr_hit=0.
- retire_valid=1 for 5 cycles with stall=1 on 2 of them -> instr_cnt=3; read 0xC82 -> 0.
- Write 0xB00=32'hFFFF_FFFE, then run 3 cycles -> cycle=64'h1_0000_0001 (carry into high half); 0xC80 reads 1.
- Write mcycleh=32'hFFFF_FFFF and mcycle=32'hFFFF_FFFF on consecutive cycles, then 1 free cycle -> cycle=0 (wrap), no X.
- Write 0x320=32'h5 -> from the next edge, cycle and instr_cnt frozen despite retire_valid=1; write 0x320=0 -> counting resumes, +1 on the following edge.
- Write 0xC02=32'h55 -> ignored, instr_cnt unchanged; write 0xB02=32'h55 with retire_valid=1 the same cycle -> instr_cnt[31:0]=0x55, not 0x56.
- Assert rst_n=0 between clock edges mid-count -> cycle and instr_cnt read 0 immediately, before the next edge.
